// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update controller.
//   bp_upd_state_e : controller mode (normal draining vs. table init walk)
//   bp_upd_entry_t : one queued predictor update record
// The entry index field is sized for the largest supported table. Users
// keep only the low $clog2(BhtSize) bits.
package bp_update_ctrl_pkg;

    localparam int unsigned BpIdxMaxW = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } bp_upd_state_e;

    typedef struct packed {
        logic                 jal;
        logic [BpIdxMaxW-1:0] idx;
        logic                 taken;
        logic [31:0]          target;
    } bp_upd_entry_t;

    // jal records always train as taken.
    function automatic bp_upd_entry_t make_entry(
        input logic                 is_jal,
        input logic [BpIdxMaxW-1:0] idx,
        input logic                 taken,
        input logic [31:0]          target
    );
        bp_upd_entry_t e;
        e.jal    = is_jal;
        e.idx    = idx;
        e.taken  = taken | is_jal;
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: synchronous FIFO with 2 write slots and 1 read port, plus a flush.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   flush_i              empty the queue (takes priority over push and pop)
//   wr_en_i[1:0]         per-slot write enable; slot0 is stored ahead of slot1
//   wr_data0_i/1_i       slot write data
//   rd_en_i              pop the head
//   rd_data_o            head entry
//   empty_o, full_o      pointer-compare status
//   free2_o              at least two free entries, from registered pointers only
module bp_upd_fifo
    import bp_update_ctrl_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic [1:0]    wr_en_i,
    input  bp_upd_entry_t wr_data0_i,
    input  bp_upd_entry_t wr_data1_i,
    input  logic          rd_en_i,
    output bp_upd_entry_t rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          free2_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]   wptr_q, rptr_q;
    logic [AW:0]   wptr1;
    logic [AW:0]   count;
    logic [AW:0]   n_wr;
    bp_upd_entry_t mem_q [Depth];

    assign count     = wptr_q - rptr_q;
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign free2_o   = (count <= (AW+1)'(Depth - 2));
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    // If only slot1 is written, it goes to the current write slot.
    assign wptr1 = wptr_q + (AW+1)'(wr_en_i[0]);
    assign n_wr  = (AW+1)'(wr_en_i[0]) + (AW+1)'(wr_en_i[1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_q + n_wr;
            if (rd_en_i) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i[0]) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data0_i;
        end
        if (wr_en_i[1]) begin
            mem_q[wptr1[AW-1:0]] <= wr_data1_i;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller. All BHT/BTB/JTB writes go through one
// write port.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   init_req_i, init_val_i       start (or restart) the table init walk with a value
//   init_busy_o                  init walk in progress
//   ex_*_i                       two resolved EX records per cycle (slot0 is older)
//   ex_rdy_o                     queue can take two records this cycle
//   upd_valid_o / upd_ready_i    write handshake toward the tables
//   upd_init_o                   init write to all tables at upd_idx_o
//   upd_jal_o                    1 = JTB update, 0 = BHT/BTB update
//   upd_idx_o                    table index (JTB uses the low bits)
//   upd_taken_o, upd_target_o    branch outcome and target to write
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int unsigned BhtSize   = 16,
    parameter int unsigned JtbSize   = 4,
    parameter int unsigned FifoDepth = 4,
    localparam int unsigned IdxW     = $clog2(BhtSize)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            init_req_i,
    input  logic [31:0]     init_val_i,
    output logic            init_busy_o,
    input  logic [1:0]      ex_valid_i,
    input  logic [1:0]      ex_is_branch_i,
    input  logic [1:0]      ex_is_jal_i,
    input  logic [1:0]      ex_taken_i,
    input  logic [31:0]     ex_pc0_i,
    input  logic [31:0]     ex_pc1_i,
    input  logic [31:0]     ex_target0_i,
    input  logic [31:0]     ex_target1_i,
    output logic            ex_rdy_o,
    output logic            upd_valid_o,
    input  logic            upd_ready_i,
    output logic            upd_init_o,
    output logic            upd_jal_o,
    output logic [IdxW-1:0] upd_idx_o,
    output logic            upd_taken_o,
    output logic [31:0]     upd_target_o
);

    if (JtbSize > BhtSize || FifoDepth < 2) begin : g_bad_params
        $error("bp_update_ctrl: need JtbSize <= BhtSize and FifoDepth >= 2");
    end

    bp_upd_state_e   state_q, state_d;
    logic [IdxW-1:0] init_cnt_q;
    logic [31:0]     init_val_q;

    logic [1:0]      elig;
    logic [1:0]      wr_en;
    bp_upd_entry_t   ent0, ent1, head;
    logic            fifo_empty, fifo_full, fifo_free2;
    logic            pop;
    logic            in_run;

    assign in_run = (state_q == ST_RUN);
    assign elig   = ex_valid_i & (ex_is_branch_i | ex_is_jal_i);

    assign ent0 = make_entry(ex_is_jal_i[0], BpIdxMaxW'(ex_pc0_i[IdxW:1]),
                             ex_taken_i[0], ex_target0_i);
    assign ent1 = make_entry(ex_is_jal_i[1], BpIdxMaxW'(ex_pc1_i[IdxW:1]),
                             ex_taken_i[1], ex_target1_i);

    // Pushes use only registered occupancy. A cycle that starts an init walk
    // flushes the queue, so no new records are stored in that cycle.
    assign wr_en = (in_run && fifo_free2 && !init_req_i) ? elig : 2'b00;
    assign pop   = in_run && !fifo_empty && upd_ready_i;

    bp_upd_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (init_req_i),
        .wr_en_i    (wr_en),
        .wr_data0_i (ent0),
        .wr_data1_i (ent1),
        .rd_en_i    (pop),
        .rd_data_o  (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .free2_o    (fifo_free2)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            init_cnt_q <= '0;
            init_val_q <= '0;
        end else begin
            state_q <= state_d;
            if (init_req_i) begin
                init_cnt_q <= '0;
                init_val_q <= init_val_i;
            end else if (state_q == ST_INIT && upd_ready_i) begin
                init_cnt_q <= init_cnt_q + IdxW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        init_busy_o  = 1'b0;
        ex_rdy_o     = fifo_free2;
        upd_valid_o  = 1'b0;
        upd_init_o   = 1'b0;
        upd_jal_o    = 1'b0;
        upd_idx_o    = '0;
        upd_taken_o  = 1'b0;
        upd_target_o = '0;

        unique case (state_q)
            ST_RUN: begin
                if (init_req_i) begin
                    state_d = ST_INIT;
                end
                // Outputs are zero while the queue is empty. This keeps stale
                // entries from showing on the port.
                if (!fifo_empty) begin
                    upd_valid_o  = 1'b1;
                    upd_jal_o    = head.jal;
                    upd_idx_o    = head.idx[IdxW-1:0];
                    upd_taken_o  = head.taken;
                    upd_target_o = head.target;
                end
            end
            ST_INIT: begin
                // A restart request wins over finishing the last index.
                if (!init_req_i && upd_ready_i && init_cnt_q == IdxW'(BhtSize - 1)) begin
                    state_d = ST_RUN;
                end
                init_busy_o  = 1'b1;
                ex_rdy_o     = 1'b1;
                upd_valid_o  = 1'b1;
                upd_init_o   = 1'b1;
                upd_idx_o    = init_cnt_q;
                upd_target_o = init_val_q;
            end
            default: state_d = ST_RUN;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{ex_pc0_i, ex_pc1_i, head.idx, fifo_full};

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl. A queue-based reference model predicts the
// outputs and is checked every cycle. Directed scenarios also check
// hand-computed literal values.
module tb_bp_update_ctrl;

    localparam int unsigned BHT   = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic [31:0] init_val = '0;
    logic        init_busy;
    logic [1:0]  ex_valid = '0, ex_is_branch = '0, ex_is_jal = '0, ex_taken = '0;
    logic [31:0] ex_pc0 = '0, ex_pc1 = '0, ex_target0 = '0, ex_target1 = '0;
    logic        ex_rdy;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic        upd_init, upd_jal, upd_taken;
    logic [3:0]  upd_idx;
    logic [31:0] upd_target;

    bp_update_ctrl #(
        .BhtSize   (BHT),
        .JtbSize   (4),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .init_req_i     (init_req),
        .init_val_i     (init_val),
        .init_busy_o    (init_busy),
        .ex_valid_i     (ex_valid),
        .ex_is_branch_i (ex_is_branch),
        .ex_is_jal_i    (ex_is_jal),
        .ex_taken_i     (ex_taken),
        .ex_pc0_i       (ex_pc0),
        .ex_pc1_i       (ex_pc1),
        .ex_target0_i   (ex_target0),
        .ex_target1_i   (ex_target1),
        .ex_rdy_o       (ex_rdy),
        .upd_valid_o    (upd_valid),
        .upd_ready_i    (upd_ready),
        .upd_init_o     (upd_init),
        .upd_jal_o      (upd_jal),
        .upd_idx_o      (upd_idx),
        .upd_taken_o    (upd_taken),
        .upd_target_o   (upd_target)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          jal;
        int unsigned idx;
        bit          taken;
        logic [31:0] target;
    } rec_t;

    rec_t        mq[$];
    bit          m_busy;
    int unsigned m_idx;
    logic [31:0] m_val;

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_idx  = 0;
        m_val  = '0;
    endtask

    task automatic model_step();
        bit   rdy_pre;
        rec_t r;
        rdy_pre = m_busy || (mq.size() <= int'(DEPTH) - 2);
        if (m_busy) begin
            if (init_req) begin
                m_idx = 0;
                m_val = init_val;
            end else if (upd_ready) begin
                if (m_idx == BHT - 1) m_busy = 0;
                m_idx = (m_idx + 1) % BHT;
            end
        end else begin
            if (mq.size() > 0 && upd_ready) void'(mq.pop_front());
            if (init_req) begin
                mq.delete();
                m_busy = 1;
                m_idx  = 0;
                m_val  = init_val;
            end else if (rdy_pre) begin
                if (ex_valid[0] && (ex_is_branch[0] || ex_is_jal[0])) begin
                    r.jal = ex_is_jal[0]; r.idx = (ex_pc0 >> 1) % BHT;
                    r.taken = ex_is_jal[0] ? 1'b1 : ex_taken[0]; r.target = ex_target0;
                    mq.push_back(r);
                end
                if (ex_valid[1] && (ex_is_branch[1] || ex_is_jal[1])) begin
                    r.jal = ex_is_jal[1]; r.idx = (ex_pc1 >> 1) % BHT;
                    r.taken = ex_is_jal[1] ? 1'b1 : ex_taken[1]; r.target = ex_target1;
                    mq.push_back(r);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          e_valid, e_init, e_jal, e_taken, e_busy, e_rdy;
    logic [31:0] e_idx, e_tgt;

    initial begin
        forever begin
            @(negedge clk);
            e_busy = m_busy;
            e_rdy  = m_busy || (mq.size() <= int'(DEPTH) - 2);
            e_valid = 0; e_init = 0; e_jal = 0; e_taken = 0; e_idx = 0; e_tgt = 0;
            if (m_busy) begin
                e_valid = 1; e_init = 1; e_idx = m_idx; e_tgt = m_val;
            end else if (mq.size() > 0) begin
                e_valid = 1; e_jal = mq[0].jal; e_taken = mq[0].taken;
                e_idx = mq[0].idx; e_tgt = mq[0].target;
            end
            check("cyc_busy",   32'(init_busy),  32'(e_busy));
            check("cyc_rdy",    32'(ex_rdy),     32'(e_rdy));
            check("cyc_valid",  32'(upd_valid),  32'(e_valid));
            check("cyc_init",   32'(upd_init),   32'(e_init));
            check("cyc_jal",    32'(upd_jal),    32'(e_jal));
            check("cyc_taken",  32'(upd_taken),  32'(e_taken));
            check("cyc_idx",    32'(upd_idx),    e_idx);
            check("cyc_target", upd_target,     e_tgt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_ex();
        ex_valid = '0; ex_is_branch = '0; ex_is_jal = '0; ex_taken = '0;
        ex_pc0 = '0; ex_pc1 = '0; ex_target0 = '0; ex_target1 = '0;
    endtask

    task automatic set_slot(input int s, input bit br, input bit jal, input bit tk,
                            input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid[s] = 1'b1; ex_is_branch[s] = br; ex_is_jal[s] = jal; ex_taken[s] = tk;
        if (s == 0) begin ex_pc0 = pc; ex_target0 = tgt; end
        else        begin ex_pc1 = pc; ex_target1 = tgt; end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_valid", 32'(upd_valid), 0);
        check("rst_rdy",   32'(ex_rdy),    1);
        check("rst_busy",  32'(init_busy), 0);

        // Init walk over all 16 indices
        upd_ready = 1; init_val = 32'h8000_0000; init_req = 1;
        step();
        init_req = 0;
        for (int k = 0; k < 16; k++) begin
            check("walk_idx",  32'(upd_idx),  k);
            check("walk_init", 32'(upd_init), 1);
            check("walk_tgt",  upd_target,   32'h8000_0000);
            step();
        end
        check("walk_done", 32'(init_busy), 0);

        // Dual push, slot0 enters first
        set_slot(0, 1, 0, 1, 32'h104, 32'h200);
        set_slot(1, 0, 1, 0, 32'h108, 32'h300);
        step();
        clear_ex();
        check("dual0_valid", 32'(upd_valid), 1);
        check("dual0_idx",   32'(upd_idx),   2);
        check("dual0_jal",   32'(upd_jal),   0);
        check("dual0_taken", 32'(upd_taken), 1);
        check("dual0_tgt",   upd_target,    32'h200);
        step();
        check("dual1_idx",   32'(upd_idx),   4);
        check("dual1_jal",   32'(upd_jal),   1);
        check("dual1_taken", 32'(upd_taken), 1);
        check("dual1_tgt",   upd_target,    32'h300);
        step();
        check("dual_empty",  32'(upd_valid), 0);

        // Backpressure with queue filling up
        upd_ready = 0;
        set_slot(0, 1, 0, 1, 32'h2, 32'hA0);
        set_slot(1, 1, 0, 0, 32'h4, 32'hA1);
        step();
        check("bp_rdy_occ2", 32'(ex_rdy), 1);
        clear_ex();
        set_slot(0, 0, 1, 0, 32'h6, 32'hA2);
        set_slot(1, 1, 0, 1, 32'h8, 32'hA3);
        step();
        check("bp_rdy_full", 32'(ex_rdy), 0);
        clear_ex();
        set_slot(0, 1, 0, 1, 32'hA, 32'hEE);
        set_slot(1, 1, 0, 1, 32'hC, 32'hEF);
        step();
        step();
        check("bp_hold_idx", 32'(upd_idx), 1);
        check("bp_hold_tgt", upd_target,  32'hA0);
        clear_ex();
        upd_ready = 1;
        step();
        check("bp_pop1_idx",   32'(upd_idx),   2);
        check("bp_pop1_taken", 32'(upd_taken), 0);
        check("bp_pop1_rdy",   32'(ex_rdy),    0);
        step();
        check("bp_pop2_idx",   32'(upd_idx),   3);
        check("bp_pop2_taken", 32'(upd_taken), 1);
        check("bp_pop2_rdy",   32'(ex_rdy),    1);
        step();
        check("bp_pop3_tgt",   upd_target,    32'hA3);
        step();
        check("bp_empty",      32'(upd_valid), 0);

        // Filter: slot1 valid but neither branch nor jal
        set_slot(0, 1, 0, 1, 32'hA, 32'h111);
        set_slot(1, 0, 0, 1, 32'hC, 32'h222);
        step();
        clear_ex();
        check("filt_idx", 32'(upd_idx), 5);
        check("filt_tgt", upd_target,  32'h111);
        step();
        check("filt_one", 32'(upd_valid), 0);

        // Init request while the queue is draining
        upd_ready = 0;
        set_slot(0, 1, 0, 1, 32'h10, 32'hB0);
        set_slot(1, 1, 0, 1, 32'h12, 32'hB1);
        step();
        clear_ex();
        set_slot(0, 1, 0, 0, 32'h14, 32'hB2);
        step();
        check("drain_head", 32'(upd_idx), 8);
        upd_ready = 1; init_req = 1; init_val = 32'h0000_1234;
        step();
        init_req = 0;
        check("drain_busy", 32'(init_busy), 1);
        check("drain_idx0", 32'(upd_idx),   0);
        check("drain_tgt",  upd_target,    32'h1234);
        upd_ready = 0;
        step();
        step();
        check("drain_stall", 32'(upd_idx), 0);
        upd_ready = 1;
        step();
        check("drain_idx1", 32'(upd_idx), 1);
        clear_ex();
        for (int k = 0; k < 15; k++) step();
        check("drain_done",  32'(init_busy), 0);
        check("drain_noent", 32'(upd_valid), 0);

        // Restart at idx 7, then reset at idx 9
        init_val = 32'hAAAA_0000; init_req = 1;
        step();
        init_req = 0;
        for (int k = 0; k < 7; k++) step();
        check("rs_idx7", 32'(upd_idx), 7);
        init_req = 1; init_val = 32'h5555_0000;
        step();
        init_req = 0;
        check("rs_idx0", 32'(upd_idx), 0);
        check("rs_tgt",  upd_target,  32'h5555_0000);
        for (int k = 0; k < 9; k++) step();
        check("rs_idx9", 32'(upd_idx), 9);
        rst = 1;
        #1;
        check("rs_rst_valid", 32'(upd_valid), 0);
        check("rs_rst_busy",  32'(init_busy), 0);
        check("rs_rst_idx",   32'(upd_idx),   0);
        check("rs_rst_tgt",   upd_target,    0);
        check("rs_rst_rdy",   32'(ex_rdy),    1);
        step();
        rst = 0;
        step();
        step();
        check("rs_after", 32'(upd_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
